// File: rtl/param_shift_unit.sv
// -----------------------------------------------------------------------------
// param_shift_unit
//   Multi-cycle shifter that moves the operand one bit per clock.
//   A start pulse captures din/amt/mode. The unit then performs amt single-bit
//   shifts (logical left, logical right, arithmetic right or rotate left),
//   spends one more cycle entering DONE, and pulses done for one cycle.
//   ovr collects every bit that falls off the end of a non-rotating shift.
//
// Ports
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   start  : launch request, honoured only while not busy
//   din    : operand, captured at launch
//   amt    : shift count, captured at launch
//   mode   : 00 SLL, 01 SRL, 10 SRA, 11 ROL, captured at launch
//   result : registered working / final value
//   ovr    : registered sticky lost-bit flag
//   busy   : high while shifting
//   done   : one-cycle completion pulse
// -----------------------------------------------------------------------------
module param_shift_unit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [AMT_W-1:0] amt,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] result,
    output logic             ovr,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROL = 2'b11
    } mode_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] w_next_result;
    logic             r_ovr;
    logic             w_next_ovr;
    logic [AMT_W-1:0] r_count;
    logic [AMT_W-1:0] w_next_count;
    mode_t            r_mode;
    mode_t            w_next_mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_result <= '0;
            r_ovr    <= 1'b0;
            r_count  <= '0;
            r_mode   <= MODE_SLL;
        end else begin
            r_state  <= w_next_state;
            r_result <= w_next_result;
            r_ovr    <= w_next_ovr;
            r_count  <= w_next_count;
            r_mode   <= w_next_mode;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_result = r_result;
        w_next_ovr    = r_ovr;
        w_next_count  = r_count;
        w_next_mode   = r_mode;

        case (r_state)
            // DONE also accepts a launch so operations can run back-to-back.
            IDLE, DONE: begin
                if (start) begin
                    w_next_state  = SHIFT;
                    w_next_result = din;
                    w_next_count  = amt;
                    w_next_mode   = mode_t'(mode);
                    w_next_ovr    = 1'b0;
                end else begin
                    w_next_state  = IDLE;
                end
            end

            SHIFT: begin
                if (r_count != '0) begin
                    w_next_count = r_count - 1'b1;
                    case (r_mode)
                        MODE_SLL: begin
                            w_next_result = {r_result[WIDTH-2:0], 1'b0};
                            w_next_ovr    = r_ovr | r_result[WIDTH-1];
                        end
                        MODE_SRL: begin
                            w_next_result = {1'b0, r_result[WIDTH-1:1]};
                            w_next_ovr    = r_ovr | r_result[0];
                        end
                        MODE_SRA: begin
                            w_next_result = {r_result[WIDTH-1], r_result[WIDTH-1:1]};
                            w_next_ovr    = r_ovr | r_result[0];
                        end
                        MODE_ROL: begin
                            w_next_result = {r_result[WIDTH-2:0], r_result[WIDTH-1]};
                        end
                        default: ;
                    endcase
                end else begin
                    w_next_state = DONE;
                end
            end

            default: w_next_state = IDLE;
        endcase
    end

    assign result = r_result;
    assign ovr    = r_ovr;
    assign busy   = (r_state == SHIFT);
    assign done   = (r_state == DONE);

endmodule

// File: tb/tb_param_shift_unit.sv
module tb_param_shift_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] din = '0;
    logic [2:0] amt = '0;
    logic [1:0] mode = '0;
    logic [7:0] result;
    logic       ovr;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    param_shift_unit #(.WIDTH(8), .AMT_W(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .din    (din),
        .amt    (amt),
        .mode   (mode),
        .result (result),
        .ovr    (ovr),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string      name;
        logic [7:0] d;
        logic [2:0] a;
        logic [1:0] m;
        logic [7:0] exp_r;
        logic       exp_o;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: the whole shift computed in one step from the operator rules.
    task automatic model(input logic [7:0] d, input int n, input logic [1:0] m,
                         output logic [7:0] r, output logic o);
        logic [15:0] t;
        logic [7:0]  lost_mask;
        lost_mask = 8'((16'd1 << n) - 16'd1);
        r = d;
        o = 1'b0;
        case (m)
            2'b00: begin
                t = {8'h00, d} << n;
                r = t[7:0];
                o = |t[15:8];
            end
            2'b01: begin
                r = d >> n;
                o = |(d & lost_mask);
            end
            2'b10: begin
                r = 8'($signed(d) >>> n);
                o = |(d & lost_mask);
            end
            default: begin
                t = {d, d} << n;
                r = t[15:8];
                o = 1'b0;
            end
        endcase
    endtask

    // Runs from a launch until done is seen, sampling on falling edges.
    // With hold set, start stays high through the SHIFT cycles.
    task automatic wait_done(input int a, input bit hold,
                             output int cyc, output int bcnt, output bit got);
        cyc  = 0;
        bcnt = 0;
        got  = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            din  = 8'($urandom);
            amt  = 3'($urandom);
            mode = 2'($urandom);
            start = (hold && cyc < a + 1);
            if (busy) bcnt++;
            if (done) got = 1'b1;
        end
    endtask

    // Caller must be positioned at a falling edge; launches on the next rising edge.
    task automatic do_op(input string name, input logic [7:0] d, input logic [2:0] a,
                         input logic [1:0] m, input bit hold,
                         input logic [7:0] exp_r, input logic exp_o);
        int cyc, bcnt;
        bit got;
        din   = d;
        amt   = a;
        mode  = m;
        start = 1'b1;
        wait_done(int'(a), hold, cyc, bcnt, got);
        check({name, " done_seen"}, 32'(got), 32'd1);
        check({name, " latency"}, 32'(cyc), 32'(int'(a) + 2));
        check({name, " busy_cycles"}, 32'(bcnt), 32'(int'(a) + 1));
        check({name, " result"}, 32'(result), 32'(exp_r));
        check({name, " ovr"}, 32'(ovr), 32'(exp_o));
        check({name, " busy_in_done"}, 32'(busy), 32'd0);
    endtask

    // One cycle after DONE with no new start: pulse gone, values held.
    task automatic check_tail(input string name, input logic [7:0] exp_r, input logic exp_o);
        start = 1'b0;
        @(negedge clk);
        check({name, " done_pulse_width"}, 32'(done), 32'd0);
        check({name, " idle_busy"}, 32'(busy), 32'd0);
        check({name, " hold_result"}, 32'(result), 32'(exp_r));
        check({name, " hold_ovr"}, 32'(ovr), 32'(exp_o));
    endtask

    initial begin
        logic [7:0] d, er;
        logic [2:0] a;
        logic [1:0] m;
        logic       eo;
        int         extra_done, extra_busy;

        vecs[0] = '{"sll2",    8'b01101001, 3'd2, 2'b00, 8'b10100100, 1'b1};
        vecs[1] = '{"srl3",    8'b01101001, 3'd3, 2'b01, 8'b00001101, 1'b1};
        vecs[2] = '{"rol3",    8'b01101001, 3'd3, 2'b11, 8'b01001011, 1'b0};
        vecs[3] = '{"sra4",    8'b10010000, 3'd4, 2'b10, 8'b11111001, 1'b0};
        vecs[4] = '{"amt0_sll", 8'b10101010, 3'd0, 2'b00, 8'b10101010, 1'b0};
        vecs[5] = '{"amt0_sra", 8'b10101010, 3'd0, 2'b10, 8'b10101010, 1'b0};
        vecs[6] = '{"sll7",    8'hFF,       3'd7, 2'b00, 8'h80,       1'b1};
        vecs[7] = '{"sra7",    8'h80,       3'd7, 2'b10, 8'hFF,       1'b0};
        vecs[8] = '{"rol7",    8'h81,       3'd7, 2'b11, 8'hC0,       1'b0};

        // Reset state, asserted asynchronously before any clock edge matters.
        #1 rst = 1'b1;
        #1;
        check("reset result", 32'(result), 32'd0);
        check("reset ovr", 32'(ovr), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].name, vecs[i].d, vecs[i].a, vecs[i].m, 1'b0,
                  vecs[i].exp_r, vecs[i].exp_o);
            check_tail(vecs[i].name, vecs[i].exp_r, vecs[i].exp_o);
        end

        // amt=0 then an amt=7 operation with start held high and operands churning.
        do_op("amt0_rol", 8'b10101010, 3'd0, 2'b11, 1'b0, 8'b10101010, 1'b0);
        check_tail("amt0_rol", 8'b10101010, 1'b0);
        do_op("hold_start", 8'b00000011, 3'd7, 2'b01, 1'b1, 8'b00000000, 1'b1);
        check_tail("hold_start", 8'b00000000, 1'b1);
        extra_done = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        check("hold_start extra_done", 32'(extra_done), 32'd0);

        // Back-to-back: new start sampled in the DONE cycle.
        do_op("b2b_first", 8'b01101001, 3'd2, 2'b00, 1'b0, 8'b10100100, 1'b1);
        do_op("b2b_second", 8'b10010000, 3'd4, 2'b10, 1'b0, 8'b11111001, 1'b0);
        check_tail("b2b_second", 8'b11111001, 1'b0);

        // Asynchronous reset in the middle of an amt=7 left shift.
        din = 8'b01101001; amt = 3'd7; mode = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst result", 32'(result), 32'd0);
        check("midrst ovr", 32'(ovr), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        extra_done = 0;
        extra_busy = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
        check("midrst no_done", 32'(extra_done), 32'd0);
        check("midrst no_busy", 32'(extra_busy), 32'd0);
        do_op("after_rst", 8'b01101001, 3'd2, 2'b00, 1'b0, 8'b10100100, 1'b1);
        check_tail("after_rst", 8'b10100100, 1'b1);

        // Random operations against the reference, mixing idle gaps and chaining.
        for (int i = 0; i < 60; i++) begin
            d = 8'($urandom);
            a = 3'($urandom_range(0, 7));
            m = 2'($urandom_range(0, 3));
            model(d, int'(a), m, er, eo);
            do_op("rand", d, a, m, 1'b0, er, eo);
            if ($urandom_range(0, 1) == 0) begin
                check_tail("rand", er, eo);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_shift_unit.md
PARAM_SHIFT_UNIT -- requirements
Module: param_shift_unit

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits (>= 2).
REQ-002 Parameter AMT_W, default 3, shift-amount width; maximum shift is 2^AMT_W-1, which SHALL be <= WIDTH.
REQ-003 clk  input  1  rising-edge clock, sole clock domain.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  request pulse; sampled high at a rising edge while not busy launches an operation.
REQ-006 din  input  WIDTH  operand, captured at start.
REQ-007 amt  input  AMT_W  shift count, captured at start.
REQ-008 mode  input  2  00 logical left, 01 logical right, 10 arithmetic right, 11 rotate left; captured at start.
REQ-009 result  output  WIDTH  registered working/final value.
REQ-010 ovr  output  1  registered sticky flag for lost bits.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-014 In IDLE or DONE, start=1 at edge T0 SHALL load result<=din, count<=amt, latch mode, clear ovr, and enter SHIFT.
REQ-015 In SHIFT with count!=0, each edge SHALL shift result by one bit per mode and decrement count.
REQ-016 In SHIFT with count==0, the next edge SHALL enter DONE without shifting.
REQ-017 For amt=N, shifts SHALL occur at edges T1..TN; DONE is entered at T(N+1); done is high for exactly the cycle following T(N+1); total latency N+1 cycles.
REQ-018 DONE SHALL last one cycle, then IDLE unless start=1 is sampled (back-to-back launch per REQ-014).
REQ-019 busy SHALL equal 1 in SHIFT and 0 in IDLE and DONE.
REQ-020 start while busy=1 SHALL be ignored; din/amt/mode changes during SHIFT SHALL NOT affect the operation.
REQ-021 Logical left: shift in 0 at LSB; ovr |= outgoing MSB.
REQ-022 Logical right: shift in 0 at MSB; ovr |= outgoing LSB.
REQ-023 Arithmetic right: replicate MSB; ovr |= outgoing LSB.
REQ-024 Rotate left: outgoing MSB enters LSB; ovr SHALL remain 0.
REQ-025 result and ovr SHALL hold their final values from DONE through IDLE until the next start.
REQ-026 amt=0 SHALL complete with result=din, ovr=0, done one cycle after T0... i.e. at T1.

Reset
REQ-027 rst=1 SHALL immediately, without waiting for clk, force state IDLE, result=0, ovr=0, busy=0, done=0, count=0.
REQ-028 rst asserted mid-operation SHALL abort it; no done pulse SHALL follow; the first start after rst deasserts SHALL behave per REQ-014.

Verification (WIDTH=8, AMT_W=3)
REQ-029 din=01101001, amt=2, mode=00, start -> busy for 3 cycles, done after edge T3, result=10100100, ovr=1.
REQ-030 din=01101001, amt=3, mode=01 -> result=00001101, ovr=1; then mode=11 same din/amt -> result=01001011, ovr=0.
REQ-031 din=10010000, amt=4, mode=10 -> result=11111001, ovr=0, done after edge T5.
REQ-032 amt=0, din=10101010, any mode -> done after T1, result=10101010, ovr=0; start held high during SHIFT of a following amt=7 operation -> only one done pulse, result per first-captured operands.
REQ-033 Launch amt=7 mode=00, assert rst asynchronously after T3 -> result=0, busy=0, ovr=0 at once, no done; new start after release -> correct result.
REQ-034 start=1 in DONE cycle with new operands -> second operation launches with no idle cycle and correct result.
